// File: rtl/r4_otfc_quo.sv
`default_nettype none
// ============================================================================
// Module      : r4_otfc_quo
// Description : Radix-4 SRT on-the-fly quotient conversion. Keeps the Q/QM
//               register pair, returns the previous digit to the speculative
//               QDS, applies the final remainder-sign correction and presents
//               the quotient over a valid/ready handshake.
//               Optional digit one-hot checker: define R4_OTFC_ONEHOT_CHK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module r4_otfc_quo #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH/2+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid_i,
  output logic             start_ready_o,
  input  logic [CNT_W-1:0] iter_num_i,
  input  logic             dig_vld_i,
  input  logic [4:0]       quo_dig_i,
  input  logic             rem_neg_i,
  output logic [4:0]       prev_quo_dig_o,
  output logic [WIDTH-1:0] quo_o,
  output logic             quo_vld_o,
  input  logic             quo_rdy_i,
  output logic             err_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ITER = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [CNT_W-1:0] C_MAX_ITER = CNT_W'(WIDTH/2);
  localparam logic [4:0]       C_DIG_ZERO = 5'b00100;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] qm_q, qm_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [4:0]       prev_dig_q, prev_dig_d;
  logic             start_ready_q, start_ready_d;
  logic             quo_vld_q, quo_vld_d;

  logic             dig_onehot;
  logic             dig_accept;
  logic [WIDTH-1:0] q_upd, qm_upd;

  assign dig_accept = (state_q == S_ITER) && dig_vld_i;

  // Digit decode and OTFC append; anything not one-hot behaves as digit 0
  always_comb begin
    dig_onehot = 1'b1;
    q_upd      = {q_q[WIDTH-3:0], 2'b00};
    qm_upd     = {qm_q[WIDTH-3:0], 2'b11};
    case (quo_dig_i)
      5'b00001: begin  // +2
        q_upd  = {q_q[WIDTH-3:0], 2'b10};
        qm_upd = {q_q[WIDTH-3:0], 2'b01};
      end
      5'b00010: begin  // +1
        q_upd  = {q_q[WIDTH-3:0], 2'b01};
        qm_upd = {q_q[WIDTH-3:0], 2'b00};
      end
      5'b00100: begin  // 0
        q_upd  = {q_q[WIDTH-3:0], 2'b00};
        qm_upd = {qm_q[WIDTH-3:0], 2'b11};
      end
      5'b01000: begin  // -1
        q_upd  = {qm_q[WIDTH-3:0], 2'b11};
        qm_upd = {qm_q[WIDTH-3:0], 2'b10};
      end
      5'b10000: begin  // -2
        q_upd  = {qm_q[WIDTH-3:0], 2'b10};
        qm_upd = {qm_q[WIDTH-3:0], 2'b01};
      end
      default: dig_onehot = 1'b0;
    endcase
  end

  // Next-state logic for the FSM and all datapath registers
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    q_d        = q_q;
    qm_d       = qm_q;
    quo_d      = quo_q;
    prev_dig_d = prev_dig_q;
    case (state_q)
      S_IDLE: begin
        if (start_valid_i) begin
          state_d    = S_ITER;
          cnt_d      = ((iter_num_i == '0) || (iter_num_i > C_MAX_ITER)) ? C_MAX_ITER : iter_num_i;
          q_d        = '0;
          qm_d       = '1;
          prev_dig_d = C_DIG_ZERO;
        end
      end
      S_ITER: begin
        if (dig_vld_i) begin
          q_d        = q_upd;
          qm_d       = qm_upd;
          prev_dig_d = dig_onehot ? quo_dig_i : C_DIG_ZERO;
          cnt_d      = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            state_d = S_FIN;
          end
        end
      end
      S_FIN: begin
        quo_d   = rem_neg_i ? qm_q : q_q;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (quo_rdy_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Handshake outputs are registered copies of the upcoming state
    start_ready_d = (state_d == S_IDLE);
    quo_vld_d     = (state_d == S_DONE);
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      q_q           <= '0;
      qm_q          <= '1;
      quo_q         <= '0;
      prev_dig_q    <= C_DIG_ZERO;
      start_ready_q <= 1'b1;
      quo_vld_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      q_q           <= q_d;
      qm_q          <= qm_d;
      quo_q         <= quo_d;
      prev_dig_q    <= prev_dig_d;
      start_ready_q <= start_ready_d;
      quo_vld_q     <= quo_vld_d;
    end
  end

  assign start_ready_o  = start_ready_q;
  assign quo_vld_o      = quo_vld_q;
  assign quo_o          = quo_q;
  assign prev_quo_dig_o = prev_dig_q;

`ifdef R4_OTFC_ONEHOT_CHK_EN
  logic err_q, err_d;

  // Sticky illegal-digit flag, cleared when a new division starts
  always_comb begin
    err_d = err_q;
    if ((state_q == S_IDLE) && start_valid_i) begin
      err_d = 1'b0;
    end else if (dig_accept && !dig_onehot) begin
      err_d = 1'b1;
    end
  end

  // Error flag register
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_o = err_q;

  a_dig_onehot : assert property (@(posedge clk) disable iff (rst)
    dig_accept |-> dig_onehot)
    else $error("r4_otfc_quo: non-one-hot quotient digit %b", quo_dig_i);
`else
  assign err_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_r4_otfc_quo.sv
`default_nettype none
// ============================================================================
// Module      : tb_r4_otfc_quo
// Description : Scoreboard bench for r4_otfc_quo at WIDTH=8 with directed,
//               hand-computed digit sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_r4_otfc_quo;
  localparam int W  = 8;
  localparam int CW = $clog2(W/2+1);
`ifdef R4_OTFC_ONEHOT_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_valid_i = 1'b0;
  logic          start_ready_o;
  logic [CW-1:0] iter_num_i = '0;
  logic          dig_vld_i = 1'b0;
  logic [4:0]    quo_dig_i = 5'b00100;
  logic          rem_neg_i = 1'b0;
  logic [4:0]    prev_quo_dig_o;
  logic [W-1:0]  quo_o;
  logic          quo_vld_o;
  logic          quo_rdy_i = 1'b0;
  logic          err_o;

  int           checks = 0;
  int           fails  = 0;
  logic [W-1:0] exp_q[$];
  bit           exp_err = 1'b0;

  r4_otfc_quo #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .start_valid_i(start_valid_i), .start_ready_o(start_ready_o),
    .iter_num_i(iter_num_i),
    .dig_vld_i(dig_vld_i), .quo_dig_i(quo_dig_i),
    .rem_neg_i(rem_neg_i), .prev_quo_dig_o(prev_quo_dig_o),
    .quo_o(quo_o), .quo_vld_o(quo_vld_o), .quo_rdy_i(quo_rdy_i),
    .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every completed output handshake is compared to the next expected quotient
  always @(negedge clk) begin
    if (!rst && quo_vld_o && quo_rdy_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL sb_unexpected actual=%0h required=none", quo_o);
      end else begin
        chk("sb_quo", quo_o, exp_q.pop_front());
      end
    end
  end

  // One division; digit i sits at digs[5*i +: 5], expected prev digit at exp_prev[5*i +: 5]
  task automatic run_div(input logic [CW-1:0] iter, input int nd, input logic [19:0] digs,
                         input logic [19:0] exp_prev, input logic rem,
                         input logic [W-1:0] exp_quo, input bit stall, input bit bp);
    bit ill;
    exp_q.push_back(exp_quo);
    chk("start_ready_idle", start_ready_o, 1);
    start_valid_i = 1'b1;
    iter_num_i    = iter;
    step();
    start_valid_i = 1'b0;
    iter_num_i    = '0;
    exp_err       = 1'b0;
    chk("start_ready_busy", start_ready_o, 0);
    chk("prev_after_start", prev_quo_dig_o, 5'b00100);
    chk("err_after_start", err_o, 0);
    for (int i = 0; i < nd; i++) begin
      if (stall && i > 0) begin
        dig_vld_i = 1'b0;
        quo_dig_i = 5'b10000;
        step();
        step();
        chk("prev_hold_stall", prev_quo_dig_o, exp_prev[(i-1)*5 +: 5]);
      end
      dig_vld_i = 1'b1;
      quo_dig_i = digs[i*5 +: 5];
      ill = ($countones(digs[i*5 +: 5]) != 1);
      step();
      dig_vld_i = 1'b0;
      quo_dig_i = 5'b00001;
      if (ill && CHK) exp_err = 1'b1;
      chk("prev_dig", prev_quo_dig_o, exp_prev[i*5 +: 5]);
      chk("err_iter", err_o, exp_err);
    end
    // FIN cycle: a digit offered here must be ignored
    chk("vld_in_fin", quo_vld_o, 0);
    rem_neg_i = rem;
    dig_vld_i = 1'b1;
    quo_dig_i = 5'b10000;
    step();
    rem_neg_i = ~rem;
    dig_vld_i = 1'b0;
    chk("vld_latency", quo_vld_o, 1);
    chk("err_done", err_o, exp_err);
    chk("prev_hold_fin", prev_quo_dig_o, exp_prev[(nd-1)*5 +: 5]);
    if (bp) begin
      start_valid_i = 1'b1;
      for (int c = 0; c < 5; c++) begin
        chk("bp_vld", quo_vld_o, 1);
        chk("bp_quo", quo_o, exp_quo);
        chk("bp_start_ignored", start_ready_o, 0);
        step();
      end
      start_valid_i = 1'b0;
    end
    quo_rdy_i = 1'b1;
    step();
    quo_rdy_i = 1'b0;
    rem_neg_i = 1'b0;
    chk("idle_after_hs", start_ready_o, 1);
    chk("vld_dropped", quo_vld_o, 0);
  endtask

  initial begin
    step();
    step();
    rst = 1'b0;
    chk("rst_start_ready", start_ready_o, 1);
    chk("rst_quo_vld", quo_vld_o, 0);
    chk("rst_quo", quo_o, 0);
    chk("rst_prev", prev_quo_dig_o, 5'b00100);
    chk("rst_err", err_o, 0);

    // +2,+2,+2,+2 -> AA
    run_div(3'd4, 4, {5'b00001, 5'b00001, 5'b00001, 5'b00001},
            {5'b00001, 5'b00001, 5'b00001, 5'b00001}, 1'b0, 8'hAA, 1'b0, 1'b0);
    // +1,-1,0,+2 with negative remainder -> QM = 31
    run_div(3'd4, 4, {5'b00001, 5'b00100, 5'b01000, 5'b00010},
            {5'b00001, 5'b00100, 5'b01000, 5'b00010}, 1'b1, 8'h31, 1'b0, 1'b0);
    // single -2 iteration -> FE
    run_div(3'd1, 1, {15'd0, 5'b10000}, {15'd0, 5'b10000}, 1'b0, 8'hFE, 1'b0, 1'b0);
    // iter 0 clamps to 4: -2,+1,+1,+1 -> 95
    run_div(3'd0, 4, {5'b00010, 5'b00010, 5'b00010, 5'b10000},
            {5'b00010, 5'b00010, 5'b00010, 5'b10000}, 1'b0, 8'h95, 1'b0, 1'b0);
    // iter 7 clamps to 4, stalls and backpressure: -1,+2,-2,+1 rem neg -> D8
    run_div(3'd7, 4, {5'b00010, 5'b10000, 5'b00001, 5'b01000},
            {5'b00010, 5'b10000, 5'b00001, 5'b01000}, 1'b1, 8'hD8, 1'b1, 1'b1);

    // Reset in the middle of ITER
    start_valid_i = 1'b1;
    iter_num_i    = 3'd4;
    step();
    start_valid_i = 1'b0;
    dig_vld_i     = 1'b1;
    quo_dig_i     = 5'b00001;
    step();
    step();
    dig_vld_i = 1'b0;
    rst       = 1'b1;
    step();
    rst       = 1'b0;
    chk("midrst_start_ready", start_ready_o, 1);
    chk("midrst_quo_vld", quo_vld_o, 0);
    chk("midrst_quo", quo_o, 0);
    chk("midrst_prev", prev_quo_dig_o, 5'b00100);
    chk("midrst_err", err_o, 0);
    // +1 x4 -> 55
    run_div(3'd4, 4, {5'b00010, 5'b00010, 5'b00010, 5'b00010},
            {5'b00010, 5'b00010, 5'b00010, 5'b00010}, 1'b0, 8'h55, 1'b0, 1'b0);

    // Illegal digit 00011 decodes as 0: +1,0,+2,-1 -> 47
    run_div(3'd4, 4, {5'b01000, 5'b00001, 5'b00011, 5'b00010},
            {5'b01000, 5'b00001, 5'b00100, 5'b00010}, 1'b0, 8'h47, 1'b0, 1'b0);
    chk("err_held_idle", err_o, exp_err);
    // The next start clears the error flag
    run_div(3'd1, 1, {15'd0, 5'b00010}, {15'd0, 5'b00010}, 1'b0, 8'h01, 1'b0, 1'b0);

    step();
    chk("sb_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/r4_otfc_quo.md
# r4_otfc_quo

Radix-4 on-the-fly quotient conversion (OTFC) stage for the radix-4 SRT integer divider iteration loop. It sits directly downstream of the quotient-digit-selection (QDS) logic and consumes one signed-digit quotient digit per accepted iteration. It maintains the Q/QM register pair and registers the previous digit, which feeds back to the speculative QDS. After the last iteration it applies the final remainder-sign correction and presents the quotient over a valid/ready handshake.

## Interface
Parameters:
- WIDTH, 32: quotient width in bits. Must be even and ≥ 4.
- CNT_W, $clog2(WIDTH/2+1): width of the iteration count. Derived; do not override.

Ports:
- clk  in  1  clock.
- rst  in  1  reset. Synchronous, active-high. The block has one clock, and `rst` is sampled on the rising edge of `clk`.
- start_valid_i  in  1  start request for a new division.
- start_ready_o  out  1  high only in IDLE.
- iter_num_i  in  CNT_W  number of radix-4 iterations. Latched when start is accepted.
- dig_vld_i  in  1  `quo_dig_i` is valid this cycle.
- quo_dig_i  in  5  one-hot digit. [4]=−2, [3]=−1, [2]=0, [1]=+1, [0]=+2.
- rem_neg_i  in  1  final remainder is negative. Sampled only in FIN.
- prev_quo_dig_o  out  5  registered last accepted digit, one-hot, same encoding as `quo_dig_i`. Feeds the QDS speculation select.
- quo_o  out  WIDTH  final corrected quotient, two's complement.
- quo_vld_o  out  1  `quo_o` is valid.
- quo_rdy_i  in  1  consumer accepts `quo_o`.
- err_o  out  1  sticky illegal-digit flag. See Configuration.

## Operation
- FSM states: IDLE, ITER, FIN, DONE. Reset state is IDLE.
- IDLE → ITER on `start_valid_i`:
  - Latch `iter_num_i` into `cnt`. Values 0 or > WIDTH/2 are clamped to WIDTH/2.
  - Set Q = 0, QM = all ones (−1), `prev_quo_dig_o` = 5'b00100, `err_o` = 0.
- In ITER, each cycle with `dig_vld_i` = 1 accepts a digit q and decrements `cnt`. A cycle with `dig_vld_i` = 0 is a stall: all state holds.
- OTFC update (shift left by 2, append 2 bits; the top 2 bits are dropped):
  - q > 0: Q ← {Q, q}, QM ← {Q, q−1}.
  - q = 0: Q ← {Q, 2'b00}, QM ← {QM, 2'b11}.
  - q < 0: Q ← {QM, 4+q}, QM ← {QM, 3+q}.
- Invariant: QM = Q − 1 (mod 2^WIDTH) after every update.
- `prev_quo_dig_o` ← `quo_dig_i` on every accepted digit.
- A non-one-hot digit (zero bits set or more than one) is treated as digit 0, and `prev_quo_dig_o` ← 5'b00100.
- ITER → FIN when the digit accepted makes `cnt` reach 0.
- FIN lasts exactly 1 cycle: `quo_o` ← `rem_neg_i` ? QM : Q. Then go to DONE.
- In DONE, `quo_vld_o` = 1 and `quo_o` is stable. DONE → IDLE in the cycle where `quo_rdy_i` = 1.
- Inputs ignored outside their states:
  - `dig_vld_i` outside ITER.
  - `start_valid_i` outside IDLE.
  - `rem_neg_i` outside FIN.
- Reset in any state, including mid-ITER, returns to IDLE.

## Timing
- Reset values: `start_ready_o` = 1, `quo_vld_o` = 0, `quo_o` = 0, `prev_quo_dig_o` = 5'b00100, `err_o` = 0, Q = 0, QM = all ones.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Cycle timeline:
  - Start accepted at cycle T: ITER from T+1, and the first digit can be accepted at T+1.
  - `prev_quo_dig_o` for the digit accepted at cycle k is visible at k+1. This is the one-cycle timing QDS requires.
  - Last digit accepted at L: FIN at L+1, `quo_vld_o` = 1 from L+2.
- Minimum start-to-valid time, with no stalls: N+2 cycles for N iterations.
- Back-to-back operation: after the handshake completes in DONE, `start_ready_o` = 1 in the next cycle.

## Configuration
- `R4_OTFC_ONEHOT_CHK_EN`, when defined:
  - The digit one-hot checker is compiled in.
  - An accepted non-one-hot `quo_dig_i` sets `err_o`. It stays set until the next start is accepted or reset.
  - An SVA assertion fires in simulation on the same condition.
- When undefined:
  - `err_o` is tied to 0 and no checker logic or assertion exists.
  - Digit decode (non-one-hot treated as 0) is identical in both builds.

## Test plan
- WIDTH=8, N=4, digits +2,+2,+2,+2, `rem_neg_i`=0 → `quo_o`=8'hAA, `quo_vld_o` at cycle L+2.
- WIDTH=8, N=4, digits +1,−1,0,+2, `rem_neg_i`=1 → Q=8'h32, QM=8'h31, `quo_o`=8'h31. `prev_quo_dig_o` sequence 00010, 01000, 00100, 00001.
- WIDTH=8, N=1, first digit −2, `rem_neg_i`=0 → `quo_o`=8'hFE. Repeat with `iter_num_i`=0 → treated as 4 iterations.
- Stalls and backpressure: `dig_vld_i` toggled 1,0,0,1,…, `quo_rdy_i` held low for 5 cycles → `quo_o` and `quo_vld_o` stable throughout, `start_valid_i` ignored, IDLE one cycle after `quo_rdy_i`=1.
- `rst` asserted after 2 of 4 digits → next cycle IDLE with all reset values. A new division then produces a correct result.
- With `R4_OTFC_ONEHOT_CHK_EN`: digit 5'b00011 → treated as 0 and `err_o`=1 until the next start. Without the macro: `err_o` stays 0 and the quotient matches.
